// File: rtl/sp_icache_ctrl_slave.sv
// Instruction-cache control slave: enable/disable/flush handshakes,
// refill tracking, fetch statistics counters.
module sp_icache_ctrl_slave #(
    parameter  int NB_OUTSTANDING = 4,
    localparam int OCNT_W         = $clog2(NB_OUTSTANDING + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ctrl_req_enable_i,
    output logic        ctrl_ack_enable_o,
    input  logic        ctrl_req_disable_i,
    output logic        ctrl_ack_disable_o,
    input  logic        flush_req_i,
    output logic        flush_ack_o,
    input  logic        icache_is_private_i,
    output logic        private_mode_o,
    input  logic        ctrl_clear_regs_i,
    input  logic        ctrl_enable_regs_i,
    output logic [31:0] ctrl_hit_count_o,
    output logic [31:0] ctrl_trans_count_o,
    output logic [31:0] ctrl_miss_count_o,
    output logic        ctrl_pending_trans_o,
    input  logic        fetch_req_i,
    input  logic        fetch_gnt_i,
    input  logic        fetch_hit_i,
    input  logic        fetch_miss_i,
    input  logic        refill_req_i,
    input  logic        refill_gnt_i,
    input  logic        refill_rvalid_i,
    output logic        cache_enable_o,
    output logic        stall_fetch_o,
    output logic        tag_flush_req_o,
    input  logic        tag_flush_done_i
);

    typedef enum logic [2:0] {
        DISABLED,
        ENABLED,
        DRAIN_EN,
        DRAIN_DIS,
        DRAIN_FLUSH,
        FLUSH,
        ACK
    } state_e;

    localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(NB_OUTSTANDING);

    state_e state_q, state_d;
    logic cache_en_q, cache_en_d;
    logic ack_en_q, ack_en_d;
    logic ack_dis_q, ack_dis_d;
    logic ack_fl_q, ack_fl_d;
    logic private_q;
    logic [OCNT_W-1:0] ocnt_q;
    logic [31:0] hit_cnt_q, trans_cnt_q, miss_cnt_q;
    logic acks_idle, ack_done, drained;
    logic refill_inc;

    assign acks_idle = ~(ack_en_q | ack_dis_q | ack_fl_q);
    assign drained   = (ocnt_q == '0);
    assign ack_done  = (ack_en_q  & ~ctrl_req_enable_i)
                     | (ack_dis_q & ~ctrl_req_disable_i)
                     | (ack_fl_q  & ~flush_req_i);

    always_comb begin
        state_d    = state_q;
        cache_en_d = cache_en_q;
        ack_en_d   = ack_en_q;
        ack_dis_d  = ack_dis_q;
        ack_fl_d   = ack_fl_q;
        case (state_q)
            DISABLED, ENABLED: begin
                if (acks_idle) begin
                    if (flush_req_i)             state_d = DRAIN_FLUSH;
                    else if (ctrl_req_disable_i) state_d = DRAIN_DIS;
                    else if (ctrl_req_enable_i)  state_d = DRAIN_EN;
                end
            end
            DRAIN_EN: begin
                if (drained) begin
                    state_d    = ACK;
                    cache_en_d = 1'b1;
                    ack_en_d   = 1'b1;
                end
            end
            DRAIN_DIS: begin
                if (drained) begin
                    state_d    = ACK;
                    cache_en_d = 1'b0;
                    ack_dis_d  = 1'b1;
                end
            end
            DRAIN_FLUSH: begin
                if (drained) state_d = FLUSH;
            end
            FLUSH: begin
                if (tag_flush_done_i) begin
                    state_d  = ACK;
                    ack_fl_d = 1'b1;
                end
            end
            ACK: begin
                // Ack is registered on entry, so it drops with the exit edge.
                if (ack_done) begin
                    ack_en_d  = 1'b0;
                    ack_dis_d = 1'b0;
                    ack_fl_d  = 1'b0;
                    state_d   = cache_en_q ? ENABLED : DISABLED;
                end
            end
            default: state_d = DISABLED;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= DISABLED;
            cache_en_q <= 1'b0;
            ack_en_q   <= 1'b0;
            ack_dis_q  <= 1'b0;
            ack_fl_q   <= 1'b0;
            private_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cache_en_q <= cache_en_d;
            ack_en_q   <= ack_en_d;
            ack_dis_q  <= ack_dis_d;
            ack_fl_q   <= ack_fl_d;
            if (state_q == DISABLED) private_q <= icache_is_private_i;
        end
    end

    assign refill_inc = refill_req_i & refill_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ocnt_q <= '0;
        end else if (refill_inc && !refill_rvalid_i && ocnt_q != OCNT_MAX) begin
            ocnt_q <= ocnt_q + OCNT_W'(1);
        end else if (refill_rvalid_i && !refill_inc && ocnt_q != '0) begin
            ocnt_q <= ocnt_q - OCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q   <= '0;
            trans_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else if (ctrl_clear_regs_i) begin
            hit_cnt_q   <= '0;
            trans_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else if (ctrl_enable_regs_i) begin
            if (fetch_hit_i && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (fetch_req_i && fetch_gnt_i && trans_cnt_q != '1)
                trans_cnt_q <= trans_cnt_q + 32'd1;
            if (fetch_miss_i && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign ctrl_ack_enable_o    = ack_en_q;
    assign ctrl_ack_disable_o   = ack_dis_q;
    assign flush_ack_o          = ack_fl_q;
    assign cache_enable_o       = cache_en_q;
    assign private_mode_o       = private_q;
    assign ctrl_hit_count_o     = hit_cnt_q;
    assign ctrl_trans_count_o   = trans_cnt_q;
    assign ctrl_miss_count_o    = miss_cnt_q;
    assign stall_fetch_o        = (state_q != DISABLED) && (state_q != ENABLED);
    assign tag_flush_req_o      = (state_q == FLUSH);
    assign ctrl_pending_trans_o = !drained
                                || state_q == DRAIN_EN || state_q == DRAIN_DIS
                                || state_q == DRAIN_FLUSH || state_q == FLUSH;

endmodule

// File: tb/tb_sp_icache_ctrl_slave.sv
// Directed bench for sp_icache_ctrl_slave: counter vector table plus
// hand sequences for handshakes, drain, flush, saturation and reset.
module tb_sp_icache_ctrl_slave;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_en, ack_en, req_dis, ack_dis, flush_req, flush_ack;
    logic        is_priv, priv_mode, clr, en_regs;
    logic [31:0] hit_cnt, trans_cnt, miss_cnt;
    logic        pending;
    logic        f_req, f_gnt, f_hit, f_miss;
    logic        r_req, r_gnt, r_rvalid;
    logic        cache_en, stall, tag_req, tag_done;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    sp_icache_ctrl_slave #(.NB_OUTSTANDING(4)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .ctrl_req_enable_i   (req_en),
        .ctrl_ack_enable_o   (ack_en),
        .ctrl_req_disable_i  (req_dis),
        .ctrl_ack_disable_o  (ack_dis),
        .flush_req_i         (flush_req),
        .flush_ack_o         (flush_ack),
        .icache_is_private_i (is_priv),
        .private_mode_o      (priv_mode),
        .ctrl_clear_regs_i   (clr),
        .ctrl_enable_regs_i  (en_regs),
        .ctrl_hit_count_o    (hit_cnt),
        .ctrl_trans_count_o  (trans_cnt),
        .ctrl_miss_count_o   (miss_cnt),
        .ctrl_pending_trans_o(pending),
        .fetch_req_i         (f_req),
        .fetch_gnt_i         (f_gnt),
        .fetch_hit_i         (f_hit),
        .fetch_miss_i        (f_miss),
        .refill_req_i        (r_req),
        .refill_gnt_i        (r_gnt),
        .refill_rvalid_i     (r_rvalid),
        .cache_enable_o      (cache_en),
        .stall_fetch_o       (stall),
        .tag_flush_req_o     (tag_req),
        .tag_flush_done_i    (tag_done)
    );

    typedef struct {
        logic        clr, en, req, gnt, hit, miss;
        logic [31:0] e_hit, e_trans, e_miss;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1,0,0,0,0,0, 0, 0, 0};
        vecs[1]  = '{0,1,1,1,1,0, 1, 1, 0};
        vecs[2]  = '{0,1,1,1,1,0, 2, 2, 0};
        vecs[3]  = '{0,1,1,0,0,1, 2, 2, 1};
        vecs[4]  = '{0,1,1,1,0,1, 2, 3, 2};
        vecs[5]  = '{0,0,1,1,1,1, 2, 3, 2};
        vecs[6]  = '{0,1,1,1,1,0, 3, 4, 2};
        vecs[7]  = '{0,1,1,1,1,0, 4, 5, 2};
        vecs[8]  = '{0,1,1,1,1,0, 5, 6, 2};
        vecs[9]  = '{0,1,1,1,1,1, 6, 7, 3};
        vecs[10] = '{0,1,1,1,1,0, 7, 8, 3};
        vecs[11] = '{0,1,1,1,0,0, 7, 9, 3};
        vecs[12] = '{0,1,0,1,0,0, 7, 9, 3};
        vecs[13] = '{0,1,1,1,0,0, 7,10, 3};
        vecs[14] = '{1,1,1,1,1,0, 0, 0, 0};
        vecs[15] = '{0,1,0,0,1,0, 1, 0, 0};

        rst_ni = 0;
        {req_en, req_dis, flush_req, is_priv, clr, en_regs} = '0;
        {f_req, f_gnt, f_hit, f_miss, r_req, r_gnt, r_rvalid, tag_done} = '0;
        #1;
        chk("rst_ack_en", ack_en, 0);
        chk("rst_cache_en", cache_en, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pending", pending, 0);
        chk("rst_tag_req", tag_req, 0);
        chk("rst_priv", priv_mode, 0);
        chk("rst_hit", hit_cnt, 0);
        step();
        rst_ni = 1;

        // private mode loads while disabled
        is_priv = 1;
        step();
        chk("priv_load", priv_mode, 1);

        // enable, no outstanding refills
        req_en = 1;
        step();
        chk("en_drain_ack", ack_en, 0);
        chk("en_drain_stall", stall, 1);
        chk("en_drain_pend", pending, 1);
        step();
        chk("en_ack", ack_en, 1);
        chk("en_cache_en", cache_en, 1);
        chk("en_ack_pend", pending, 0);
        step();
        chk("en_ack_hold", ack_en, 1);
        req_en = 0;
        step();
        chk("en_ack_drop", ack_en, 0);
        chk("en_state_stall", stall, 0);
        chk("en_cache_hold", cache_en, 1);

        is_priv = 0;
        step();
        chk("priv_ignored", priv_mode, 1);

        // disable with two refills outstanding
        r_req = 1; r_gnt = 1;
        step();
        step();
        r_req = 0; r_gnt = 0;
        chk("dis_pend_pre", pending, 1);
        chk("dis_stall_pre", stall, 0);
        req_dis = 1;
        step();
        chk("dis_wait_ack0", ack_dis, 0);
        chk("dis_wait_stall", stall, 1);
        step();
        chk("dis_wait_ack1", ack_dis, 0);
        r_rvalid = 1;
        step();
        r_rvalid = 0;
        chk("dis_one_left", ack_dis, 0);
        chk("dis_one_pend", pending, 1);
        r_rvalid = 1;
        step();
        r_rvalid = 0;
        chk("dis_zero_ack", ack_dis, 0);
        chk("dis_zero_pend", pending, 1);
        step();
        chk("dis_ack", ack_dis, 1);
        chk("dis_cache_en", cache_en, 0);
        req_dis = 0;
        step();
        chk("dis_ack_drop", ack_dis, 0);
        chk("dis_stall", stall, 0);
        step();
        chk("priv_reload", priv_mode, 0);

        // outstanding saturates at 4 and at 0
        r_req = 1; r_gnt = 1;
        repeat (5) step();
        r_req = 0; r_gnt = 0;
        r_rvalid = 1;
        repeat (3) step();
        chk("ocnt_sat_hi", pending, 1);
        step();
        chk("ocnt_empty", pending, 0);
        step();
        r_rvalid = 0;
        r_req = 1; r_gnt = 1;
        step();
        r_req = 0; r_gnt = 0;
        chk("ocnt_sat_lo", pending, 1);
        r_rvalid = 1; r_req = 1; r_gnt = 1;
        step();
        chk("ocnt_both", pending, 1);
        r_req = 0; r_gnt = 0;
        step();
        r_rvalid = 0;
        chk("ocnt_back0", pending, 0);

        // flush and enable together: flush wins
        flush_req = 1; req_en = 1;
        step();
        chk("fl_drain_tag", tag_req, 0);
        chk("fl_drain_stall", stall, 1);
        step();
        chk("fl_tag_req", tag_req, 1);
        step();
        step();
        chk("fl_tag_hold", tag_req, 1);
        chk("fl_ack_wait", flush_ack, 0);
        tag_done = 1;
        step();
        tag_done = 0;
        chk("fl_ack", flush_ack, 1);
        chk("fl_ack_en0", ack_en, 0);
        chk("fl_tag_off", tag_req, 0);
        chk("fl_cache_en", cache_en, 0);
        flush_req = 0;
        step();
        chk("fl_ack_drop", flush_ack, 0);
        chk("fl_idle_stall", stall, 0);
        step();
        chk("fl_then_en", stall, 1);
        step();
        chk("fl_en_ack", ack_en, 1);
        chk("fl_en_cache", cache_en, 1);
        req_en = 0;
        step();
        chk("fl_en_done", ack_en, 0);

        // counter vectors
        for (int i = 0; i < 16; i++) begin
            clr = vecs[i].clr; en_regs = vecs[i].en;
            f_req = vecs[i].req; f_gnt = vecs[i].gnt;
            f_hit = vecs[i].hit; f_miss = vecs[i].miss;
            step();
            chk($sformatf("vec%0d_hit", i), hit_cnt, vecs[i].e_hit);
            chk($sformatf("vec%0d_trans", i), trans_cnt, vecs[i].e_trans);
            chk($sformatf("vec%0d_miss", i), miss_cnt, vecs[i].e_miss);
        end
        {clr, f_req, f_gnt, f_hit, f_miss} = '0;

        // hit counter saturation from a preset value
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_q;
        en_regs = 1; f_hit = 1;
        step();
        chk("sat_hit1", hit_cnt, 32'hFFFF_FFFF);
        step();
        chk("sat_hit2", hit_cnt, 32'hFFFF_FFFF);
        step();
        chk("sat_hit3", hit_cnt, 32'hFFFF_FFFF);
        f_hit = 0;

        // reset in the middle of a flush
        flush_req = 1;
        step();
        step();
        chk("rf_tag_req", tag_req, 1);
        #2 rst_ni = 0;
        #1;
        chk("rf_tag_off", tag_req, 0);
        chk("rf_cache_en", cache_en, 0);
        chk("rf_stall", stall, 0);
        chk("rf_pend", pending, 0);
        chk("rf_hit", hit_cnt, 0);
        step();
        rst_ni = 1;
        step();
        chk("rf_retrig", stall, 1);
        step();
        chk("rf_tag_again", tag_req, 1);
        tag_done = 1;
        step();
        tag_done = 0;
        chk("rf_ack", flush_ack, 1);
        flush_req = 0;
        step();
        chk("rf_ack_drop", flush_ack, 0);
        chk("rf_idle", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_icache_ctrl_slave.md
SP_ICACHE_CTRL_SLAVE -- requirements
Module: sp_icache_ctrl_slave

Interface
REQ-001 SHALL have parameter NB_OUTSTANDING, default 4, max outstanding refills; OCNT_W = clog2(NB_OUTSTANDING+1).
REQ-002 SHALL have clk_i  in  1  single clock, rising edge; all state on this clock.
REQ-003 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ctrl_req_enable_i / ctrl_ack_enable_o  in/out  1  enable 4-phase handshake.
REQ-005 SHALL have ctrl_req_disable_i / ctrl_ack_disable_o  in/out  1  disable 4-phase handshake.
REQ-006 SHALL have flush_req_i / flush_ack_o  in/out  1  flush 4-phase handshake.
REQ-007 SHALL have icache_is_private_i  in  1  private/shared mode request; private_mode_o  out  1  applied mode.
REQ-008 SHALL have ctrl_clear_regs_i, ctrl_enable_regs_i  in  1  counter clear / counter enable.
REQ-009 SHALL have ctrl_hit_count_o, ctrl_trans_count_o, ctrl_miss_count_o  out  32  event counters; ctrl_pending_trans_o  out  1  activity flag.
REQ-010 SHALL have fetch_req_i, fetch_gnt_i, fetch_hit_i, fetch_miss_i  in  1  cache fetch events (hit/miss single-cycle pulses).
REQ-011 SHALL have refill_req_i, refill_gnt_i, refill_rvalid_i  in  1  refill port events.
REQ-012 SHALL have cache_enable_o, stall_fetch_o, tag_flush_req_o  out  1; tag_flush_done_i  in  1  tag-array invalidate handshake.

Function
REQ-013 SHALL implement FSM states DISABLED, ENABLED, DRAIN_EN, DRAIN_DIS, DRAIN_FLUSH, FLUSH, ACK.
REQ-014 SHALL accept a request only in DISABLED/ENABLED with all three acks low; simultaneous requests priority flush > disable > enable.
REQ-015 Enable accepted -> DRAIN_EN; disable accepted -> DRAIN_DIS; flush accepted -> DRAIN_FLUSH.
REQ-016 Drain states SHALL wait until outstanding counter == 0, checked same cycle as entry (zero outstanding: leave after 1 cycle).
REQ-017 DRAIN_EN -> ACK with cache_enable_o=1; DRAIN_DIS -> ACK with cache_enable_o=0; DRAIN_FLUSH -> FLUSH.
REQ-018 FLUSH SHALL hold tag_flush_req_o=1 until tag_flush_done_i=1, then -> ACK; cache_enable_o unchanged by flush.
REQ-019 ACK SHALL raise the matching ack the cycle after entry, hold it while its req is high, drop it the cycle after req low, then -> ENABLED if cache_enable_o else DISABLED.
REQ-020 stall_fetch_o SHALL be 1 in every state except DISABLED and ENABLED.
REQ-021 Outstanding counter: +1 on refill_req_i&refill_gnt_i, -1 on refill_rvalid_i, unchanged if both; saturate at NB_OUTSTANDING and at 0.
REQ-022 ctrl_pending_trans_o SHALL equal (outstanding != 0) OR state in {DRAIN_EN, DRAIN_DIS, DRAIN_FLUSH, FLUSH}.
REQ-023 private_mode_o SHALL load icache_is_private_i only in state DISABLED; ignored otherwise.
REQ-024 With ctrl_enable_regs_i=1: trans +1 on fetch_req_i&fetch_gnt_i, hit +1 on fetch_hit_i, miss +1 on fetch_miss_i; each saturates at 32'hFFFF_FFFF.
REQ-025 ctrl_clear_regs_i SHALL zero all three counters next cycle, overriding same-cycle increments and ctrl_enable_regs_i.
REQ-026 Counters SHALL hold when ctrl_enable_regs_i=0; counting independent of FSM state.

Reset
REQ-027 On rst_ni low, immediately: state DISABLED, all acks 0, cache_enable_o 0, tag_flush_req_o 0, stall_fetch_o 0, private_mode_o 0, counters 0, outstanding 0, ctrl_pending_trans_o 0.
REQ-028 Reset mid-handshake or mid-flush SHALL abort it; a req still high after reset release SHALL be re-accepted as new.

Verification
REQ-029 Enable, outstanding=0: req_enable high cycle 0 -> ack_enable high cycle 2, cache_enable_o=1; req low -> ack low next cycle, state ENABLED.
REQ-030 Disable with 2 refills outstanding: ack_disable stays 0, stall_fetch_o=1, pending=1 until 2 rvalid pulses; ack 1 cycle after counter hits 0, cache_enable_o=0.
REQ-031 Flush+enable same cycle while DISABLED: flush served first, tag_flush_req_o held until done, flush_ack_o; enable served after flush handshake completes.
REQ-032 Counters: enable_regs=1, 10 grants, 7 hits, 3 misses -> 10/7/3; clear_regs with simultaneous hit -> all 0 next cycle.
REQ-033 Saturation: hit counter preset to FFFF_FFFE via stimulus, 3 hits -> FFFF_FFFF; outstanding at NB_OUTSTANDING plus grant -> stays NB_OUTSTANDING.
REQ-034 rst_ni asserted during FLUSH -> tag_flush_req_o and all outputs reset immediately; held flush_req_i re-triggers flush after release.
